// File: rtl/pio_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pio_bank_pkg
// Purpose  : Shared register offsets, edge-mode encoding and the channel
//            address width helper for the avalon_pio_bank peripheral.
// Revision : 1.0 - initial release
// ============================================================================
package pio_bank_pkg;

  // Register offsets within a channel's 8-word window
  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_SET  = 3'd1;
  localparam logic [2:0] REG_CLR  = 3'd2;
  localparam logic [2:0] REG_MASK = 3'd3;
  localparam logic [2:0] REG_EDGE = 3'd4;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_mode_t;

  // Channel-index field width; a single channel still gets one address bit
  function automatic int ch_w(input int num_ch);
    if (num_ch <= 1) return 1;
    return $clog2(num_ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pio_debounce.sv
`default_nettype none
// ============================================================================
// Module   : pio_debounce
// Purpose  : Two-flop synchroniser followed by a stability-count debouncer
//            for one DATA_W-bit input channel.
// Revision : 1.0 - initial release
// ============================================================================
module pio_debounce #(
  parameter int DATA_W       = 16,
  parameter int DEBOUNCE_CYC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_pin,
  output logic [DATA_W-1:0] o_db
);

  // Wide enough for a count limit of 2^20
  localparam int c_cnt_w = 21;
  localparam logic [c_cnt_w-1:0] c_cnt_last =
      (DEBOUNCE_CYC > 0) ? c_cnt_w'(DEBOUNCE_CYC - 1) : '0;

  logic [DATA_W-1:0]  sync1_q, sync1_d;
  logic [DATA_W-1:0]  sync2_q, sync2_d;
  logic [DATA_W-1:0]  hold_q,  hold_d;   // synchroniser output one cycle ago
  logic [DATA_W-1:0]  db_q,    db_d;
  logic [c_cnt_w-1:0] cnt_q,   cnt_d;

  // Next state: count consecutive cycles in which the synchronised value is
  // unchanged and differs from the accepted value; any change restarts it.
  always_comb begin
    sync1_d = i_pin;
    sync2_d = sync1_q;
    hold_d  = sync2_q;
    db_d    = db_q;
    cnt_d   = '0;
    if (DEBOUNCE_CYC == 0) begin
      db_d = sync2_q;
    end else if ((sync2_q != db_q) && (sync2_q == hold_q)) begin
      if (cnt_q == c_cnt_last) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + c_cnt_w'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hold_q  <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hold_q  <= hold_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_db = db_q;

endmodule
`default_nettype wire

// File: rtl/avalon_pio_bank.sv
`default_nettype none
// ============================================================================
// Module   : avalon_pio_bank
// Purpose  : Multi-channel Avalon-MM PIO with fixed-direction channels,
//            input debounce, sticky edge capture (W1C) and masked irq.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_pio_bank
  import pio_bank_pkg::*;
#(
  parameter int                NUM_CH       = 4,
  parameter int                DATA_W       = 16,
  parameter logic [NUM_CH-1:0] CH_IS_OUT    = 4'b0011,
  parameter logic [31:0]       OUT_RESET    = 32'h0,
  parameter int                EDGE_MODE    = 0,
  parameter int                DEBOUNCE_CYC = 0
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic                     avs_chipselect,
  input  logic [ch_w(NUM_CH)+2:0]  avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata,
  output logic [31:0]              avs_readdata,
  input  logic [NUM_CH*DATA_W-1:0] pio_in,
  output logic [NUM_CH*DATA_W-1:0] pio_out,
  output logic                     irq
);

  localparam int                c_ch_w      = ch_w(NUM_CH);
  localparam logic [DATA_W-1:0] c_out_rst   = OUT_RESET[DATA_W-1:0];
  localparam edge_mode_t        c_edge_mode = edge_mode_t'(EDGE_MODE[1:0]);

  logic [c_ch_w-1:0] w_ch_idx;
  logic [2:0]        w_reg;
  logic              w_wr;
  logic              w_rd;
  logic [DATA_W-1:0] w_wdata;

  logic [DATA_W-1:0] w_db   [NUM_CH];
  logic [DATA_W-1:0] w_det  [NUM_CH];
  logic [DATA_W-1:0] out_q  [NUM_CH];
  logic [DATA_W-1:0] out_d  [NUM_CH];
  logic [DATA_W-1:0] mask_q [NUM_CH];
  logic [DATA_W-1:0] mask_d [NUM_CH];
  logic [DATA_W-1:0] edge_q [NUM_CH];
  logic [DATA_W-1:0] edge_d [NUM_CH];
  logic [DATA_W-1:0] prev_q [NUM_CH];
  logic [DATA_W-1:0] prev_d [NUM_CH];
  logic [31:0]       rdata_q, rdata_d;
  logic              irq_q,   irq_d;

  assign w_ch_idx = avs_address[c_ch_w+2:3];
  assign w_reg    = avs_address[2:0];
  assign w_wr     = avs_chipselect & avs_write;
  assign w_rd     = avs_chipselect & avs_read;
  assign w_wdata  = avs_writedata[DATA_W-1:0];

  if (DATA_W < 32) begin : g_wd_pad
    logic w_unused_wd;
    assign w_unused_wd = ^avs_writedata[31:DATA_W];
  end

  // Per channel: input channels get a debouncer, outputs drive their register
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    if (CH_IS_OUT[k]) begin : g_out
      logic w_unused_pin;
      assign w_unused_pin = ^pio_in[k*DATA_W +: DATA_W];
      assign w_db[k] = '0;
      assign pio_out[k*DATA_W +: DATA_W] = out_q[k];
    end else begin : g_in
      pio_debounce #(
        .DATA_W       (DATA_W),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_debounce (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .i_pin (pio_in[k*DATA_W +: DATA_W]),
        .o_db  (w_db[k])
      );
      assign pio_out[k*DATA_W +: DATA_W] = '0;
    end
  end

  // Edge detect term per channel, selected by the build-time edge mode
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_det[k] = '0;
      case (c_edge_mode)
        EDGE_FALL: w_det[k] = ~w_db[k] & prev_q[k];
        EDGE_ANY:  w_det[k] = w_db[k] ^ prev_q[k];
        default:   w_det[k] = w_db[k] & ~prev_q[k];
      endcase
    end
  end

  // Register-file next state, interrupt and read mux
  always_comb begin
    irq_d   = 1'b0;
    rdata_d = rdata_q;
    for (int k = 0; k < NUM_CH; k++) begin
      out_d[k]  = out_q[k];
      mask_d[k] = mask_q[k];
      edge_d[k] = edge_q[k];
      prev_d[k] = w_db[k];
      if (CH_IS_OUT[k]) begin
        // Output channels never capture edges or hold a mask
        mask_d[k] = '0;
        edge_d[k] = '0;
        if (w_wr && (w_ch_idx == c_ch_w'(k))) begin
          case (w_reg)
            REG_DATA: out_d[k] = w_wdata;
            REG_SET:  out_d[k] = out_q[k] | w_wdata;
            REG_CLR:  out_d[k] = out_q[k] & ~w_wdata;
            default:  out_d[k] = out_q[k];
          endcase
        end
      end else begin
        out_d[k] = '0;
        if (w_wr && (w_ch_idx == c_ch_w'(k)) && (w_reg == REG_MASK)) begin
          mask_d[k] = w_wdata;
        end
        // Clear first, then OR in new edges so a coincident edge survives
        if (w_wr && (w_ch_idx == c_ch_w'(k)) && (w_reg == REG_EDGE)) begin
          edge_d[k] = edge_q[k] & ~w_wdata;
        end
        edge_d[k] = edge_d[k] | w_det[k];
      end
      irq_d = irq_d | (|(edge_q[k] & mask_q[k]));
    end

    if (w_rd) begin
      rdata_d = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_ch_idx == c_ch_w'(k)) begin
          case (w_reg)
            REG_DATA: rdata_d[DATA_W-1:0] = CH_IS_OUT[k] ? out_q[k] : w_db[k];
            REG_MASK: rdata_d[DATA_W-1:0] = mask_q[k];
            REG_EDGE: rdata_d[DATA_W-1:0] = edge_q[k];
            default:  rdata_d = '0;
          endcase
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        out_q[k]  <= CH_IS_OUT[k] ? c_out_rst : '0;
        mask_q[k] <= '0;
        edge_q[k] <= '0;
        prev_q[k] <= '0;
      end
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        out_q[k]  <= out_d[k];
        mask_q[k] <= mask_d[k];
        edge_q[k] <= edge_d[k];
        prev_q[k] <= prev_d[k];
      end
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule
`default_nettype wire

// File: doc/avalon_pio_bank.md
Name: avalon_pio_bank

Overview:
- Parametrised multi-channel Avalon-MM PIO peripheral for the NIOS II SoC.
- Replaces the separate single-purpose PIOs (keycode, hex digits, LEDs, keys) with one bank of NUM_CH channels.
- Each channel is a fixed-direction input or output port, DATA_W bits wide.
- Adds three things the plain PIOs lack: per-channel debounce, edge capture with write-1-to-clear, and a masked, registered interrupt.

Parameters:
- NUM_CH, 4: number of channels, 1..16.
- DATA_W, 16: bits per channel, 1..32.
- CH_IS_OUT, 4'b0011: bit k = 1 makes channel k an output, 0 makes it an input. Width is NUM_CH.
- OUT_RESET, 0: reset value of every output register, truncated to DATA_W.
- EDGE_MODE, 0: edge capture mode. 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYC, 0: number of consecutive stable cycles required before an input change is accepted. 0 disables debounce. Maximum 2^20.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- avs_chipselect  in  1  slave select.
- avs_address  in  CH_W+3  address = {channel, reg[2:0]}. CH_W = max(1, clog2(NUM_CH)).
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data. Bits [DATA_W-1:0] are used.
- avs_readdata  out  32  registered read data, zero-extended.
- pio_in  in  NUM_CH*DATA_W  packed inputs. Channel k is [k*DATA_W +: DATA_W].
- pio_out  out  NUM_CH*DATA_W  packed outputs. Same packing.
- irq  out  1  level interrupt, registered.

Behaviour:
- Register map (reg offset):
  - 0 DATA: read returns the debounced input, or the output register for an output channel. Write loads the output register.
  - 1 SET: write ORs writedata into the output register.
  - 2 CLR: write ANDs the output register with ~writedata.
  - 3 MASK: per-bit interrupt mask, read/write.
  - 4 EDGE: captured edges. Read returns them; writing 1 to a bit clears that bit.
  - 5-7: read 0, writes ignored.
- Access rules:
  - Accesses take effect only when avs_chipselect is high.
  - No waitrequest. Read latency is fixed at 1 cycle: avs_readdata is updated on the clock edge after avs_read is sampled, and holds until the next read.
  - A channel index >= NUM_CH reads 0; writes to it are ignored.
- Direction rules:
  - Output channels: SET, CLR and DATA writes take effect on the next edge. pio_out reflects the register with no extra delay. MASK and EDGE stay 0; writes to them are ignored.
  - Input channels: DATA, SET and CLR writes are ignored. The pio_out bits for the channel are driven 0.
- Input path:
  - Each input bit passes through a 2-flop synchroniser, then a per-channel debouncer.
  - A pin change sampled at edge N is visible in the synchroniser output after edge N+2.
  - The debounced value updates at edge N+2+DEBOUNCE_CYC, provided the synchronised value stays constant across that whole window.
  - Any change inside the window restarts the count. A glitch shorter than DEBOUNCE_CYC cycles never propagates.
- Edge capture:
  - prev holds the debounced value from the previous cycle.
  - The detect term is db & ~prev (rising), ~db & prev (falling) or db ^ prev (any), per EDGE_MODE.
  - EDGE bits set on the edge after the debounced value changes, and are sticky.
  - If a new edge and a write-1-to-clear hit the same bit in the same cycle, the set wins.
- Interrupt:
  - irq <= OR over all input channels of (EDGE & MASK).
  - irq asserts one cycle after the EDGE bit sets, or one cycle after a MASK write exposes an already-set bit.
  - irq deasserts one cycle after a clear or mask write removes the last active bit.
- Reset values (asynchronous, reset_reset_n low):
  - Output registers = OUT_RESET.
  - MASK, EDGE, avs_readdata, irq = 0.
  - Synchroniser, debounced and prev flops = 0. No spurious edge is captured on release unless an input is already high and EDGE_MODE is rising or any; this is intended.
  - Reset mid-transfer aborts the read. readdata is 0 after release.

Decomposition:
- pio_bank_pkg holds:
  - register offsets REG_DATA..REG_EDGE;
  - the edge_mode_t enum (EDGE_RISE, EDGE_FALL, EDGE_ANY);
  - a clog2-based CH_W helper function.
- Sub-module pio_debounce (DATA_W, DEBOUNCE_CYC):
  - contains the synchroniser, stability counter and debounced register;
  - one instance is generated per input channel.

Test Plan:
- Reset with OUT_RESET=16'h00FF, then read DATA of ch0 and ch1 -> readdata = 32'h000000FF one cycle after the read; pio_out[15:0] = 16'h00FF.
- Output ch0: write DATA = 16'h1234, write SET = 16'h0F00, write CLR = 16'h0004 -> pio_out[15:0] = 16'h1F30, and read-back matches.
- Input ch2, DEBOUNCE_CYC=4, EDGE_MODE=0, MASK=16'h0001:
  - raise pio_in[32] at edge N -> DATA bit 0 = 1 at edge N+6, EDGE = 16'h0001 at N+7, irq = 1 at N+8;
  - write EDGE = 16'h0001 -> irq = 0 one cycle later.
- Same setup, 3-cycle pulse on pio_in[32] -> no change in DATA, EDGE or irq.
- EDGE_MODE=2: a new edge on bit 0 coinciding with a write-1-to-clear of bit 0 -> EDGE bit 0 stays 1.
- Read of reg 6, and of a channel index >= NUM_CH -> readdata = 0. Write to an input channel's DATA -> its pio_out bits stay 0.
